// File: rtl/axi_lite_rr_arbiter_pkg.sv
// Shared AXI-Lite payload types, widths and FSM state encodings for the round-robin arbiter.
package axi_lite_rr_arbiter_pkg;

    localparam int unsigned ADDR_LEN  = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned NUM_M_MAX = 8;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExOkay = 2'b01,
        RespSlvErr = 2'b10,
        RespDecErr = 2'b11
    } resp_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } WxDATA_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        resp_t             resp;
    } RxDATA_t;

    localparam int unsigned WxDATA_W = $bits(WxDATA_t);
    localparam int unsigned RxDATA_W = $bits(RxDATA_t);

    typedef enum logic [1:0] {
        WIdle,
        WAddr,
        WData,
        WResp
    } w_state_e;

    typedef enum logic [1:0] {
        RIdle,
        RAddr,
        RData
    } r_state_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping at N.
module rr_arbiter #(
    parameter int unsigned  N    = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            any_o,
    output logic [IdxW-1:0] gnt_idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin sharing of one AXI-Lite subordinate between NUM_M managers; independent
// read and write paths, each with a single transaction in flight.
module axi_lite_rr_arbiter
    import axi_lite_rr_arbiter_pkg::*;
#(
    parameter int unsigned  NUM_M = 2,
    localparam int unsigned IDX_W = $clog2(NUM_M)
) (
    input  logic                      aclk_i,
    input  logic                      areset_i,
    // Manager-facing ports
    input  logic [NUM_M-1:0]          s_awvalid_i,
    input  logic [NUM_M*ADDR_LEN-1:0] s_awaddr_i,
    output logic [NUM_M-1:0]          s_awready_o,
    input  logic [NUM_M-1:0]          s_wvalid_i,
    input  logic [NUM_M*WxDATA_W-1:0] s_wdata_i,
    output logic [NUM_M-1:0]          s_wready_o,
    output logic [NUM_M-1:0]          s_bvalid_o,
    output logic [1:0]                s_bresp_o,
    input  logic [NUM_M-1:0]          s_bready_i,
    input  logic [NUM_M-1:0]          s_arvalid_i,
    input  logic [NUM_M*ADDR_LEN-1:0] s_araddr_i,
    output logic [NUM_M-1:0]          s_arready_o,
    output logic [NUM_M-1:0]          s_rvalid_o,
    output logic [RxDATA_W-1:0]       s_rdata_o,
    input  logic [NUM_M-1:0]          s_rready_i,
    // Subordinate-facing port
    output logic                      m_awvalid_o,
    output logic [ADDR_LEN-1:0]       m_awaddr_o,
    input  logic                      m_awready_i,
    output logic                      m_wvalid_o,
    output logic [WxDATA_W-1:0]       m_wdata_o,
    input  logic                      m_wready_i,
    input  logic                      m_bvalid_i,
    input  logic [1:0]                m_bresp_i,
    output logic                      m_bready_o,
    output logic                      m_arvalid_o,
    output logic [ADDR_LEN-1:0]       m_araddr_o,
    input  logic                      m_arready_i,
    input  logic                      m_rvalid_i,
    input  logic [RxDATA_W-1:0]       m_rdata_i,
    output logic                      m_rready_o
);

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [IDX_W-1:0] wgnt_q, wgnt_d, wptr_q, wptr_d;
    logic [IDX_W-1:0] rgnt_q, rgnt_d, rptr_q, rptr_d;
    logic             w_any, r_any;
    logic [IDX_W-1:0] w_win, r_win;

    logic [ADDR_LEN-1:0] aw_addr [NUM_M];
    logic [ADDR_LEN-1:0] ar_addr [NUM_M];
    logic [WxDATA_W-1:0] w_data  [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
        assign aw_addr[i] = s_awaddr_i[i*ADDR_LEN +: ADDR_LEN];
        assign ar_addr[i] = s_araddr_i[i*ADDR_LEN +: ADDR_LEN];
        assign w_data[i]  = s_wdata_i[i*WxDATA_W +: WxDATA_W];
    end

    rr_arbiter #(
        .N(NUM_M)
    ) u_wr_arb (
        .req_i     (s_awvalid_i),
        .ptr_i     (wptr_q),
        .any_o     (w_any),
        .gnt_idx_o (w_win)
    );

    rr_arbiter #(
        .N(NUM_M)
    ) u_rd_arb (
        .req_i     (s_arvalid_i),
        .ptr_i     (rptr_q),
        .any_o     (r_any),
        .gnt_idx_o (r_win)
    );

    // Responses are broadcast; only the granted manager sees its valid.
    assign s_bresp_o = m_bresp_i;
    assign s_rdata_o = m_rdata_i;

    always_comb begin
        w_state_d   = w_state_q;
        wgnt_d      = wgnt_q;
        wptr_d      = wptr_q;
        m_awvalid_o = 1'b0;
        m_awaddr_o  = '0;
        s_awready_o = '0;
        m_wvalid_o  = 1'b0;
        m_wdata_o   = '0;
        s_wready_o  = '0;
        s_bvalid_o  = '0;
        m_bready_o  = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                // The winner is registered; forwarding starts the following cycle.
                if (w_any) begin
                    wgnt_d    = w_win;
                    w_state_d = WAddr;
                end
            end
            WAddr: begin
                m_awvalid_o         = 1'b1;
                m_awaddr_o          = aw_addr[wgnt_q];
                s_awready_o[wgnt_q] = m_awready_i;
                if (m_awready_i) begin
                    w_state_d = WData;
                end
            end
            WData: begin
                m_wvalid_o         = s_wvalid_i[wgnt_q];
                m_wdata_o          = w_data[wgnt_q];
                s_wready_o[wgnt_q] = m_wready_i;
                if (s_wvalid_i[wgnt_q] && m_wready_i) begin
                    w_state_d = WResp;
                end
            end
            WResp: begin
                s_bvalid_o[wgnt_q] = m_bvalid_i;
                m_bready_o         = s_bready_i[wgnt_q];
                if (m_bvalid_i && s_bready_i[wgnt_q]) begin
                    wptr_d    = IDX_W'(rr_next(32'(wgnt_q), NUM_M));
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        rgnt_d      = rgnt_q;
        rptr_d      = rptr_q;
        m_arvalid_o = 1'b0;
        m_araddr_o  = '0;
        s_arready_o = '0;
        s_rvalid_o  = '0;
        m_rready_o  = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                if (r_any) begin
                    rgnt_d    = r_win;
                    r_state_d = RAddr;
                end
            end
            RAddr: begin
                m_arvalid_o         = 1'b1;
                m_araddr_o          = ar_addr[rgnt_q];
                s_arready_o[rgnt_q] = m_arready_i;
                if (m_arready_i) begin
                    r_state_d = RData;
                end
            end
            RData: begin
                s_rvalid_o[rgnt_q] = m_rvalid_i;
                m_rready_o         = s_rready_i[rgnt_q];
                if (m_rvalid_i && s_rready_i[rgnt_q]) begin
                    rptr_d    = IDX_W'(rr_next(32'(rgnt_q), NUM_M));
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            w_state_q <= WIdle;
            wgnt_q    <= '0;
            wptr_q    <= '0;
            r_state_q <= RIdle;
            rgnt_q    <= '0;
            rptr_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            wgnt_q    <= wgnt_d;
            wptr_q    <= wptr_d;
            r_state_q <= r_state_d;
            rgnt_q    <= rgnt_d;
            rptr_q    <= rptr_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed plus randomized bench for axi_lite_rr_arbiter with a round-robin reference model.
module tb_axi_lite_rr_arbiter;
    import axi_lite_rr_arbiter_pkg::*;

    localparam int NM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NM-1:0]          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NM-1:0]          s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NM*ADDR_LEN-1:0] s_awaddr, s_araddr;
    logic [NM*WxDATA_W-1:0] s_wdata;
    logic [1:0]             s_bresp, m_bresp;
    logic [RxDATA_W-1:0]    s_rdata, m_rdata;
    logic                   m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic                   m_arvalid, m_arready, m_rvalid, m_rready;
    logic [ADDR_LEN-1:0]    m_awaddr, m_araddr;
    logic [WxDATA_W-1:0]    m_wdata;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_cnt     = 0;
    int wptr_m, rptr_m;
    int cyc_w, cyc_r, who_w, who_r;

    logic [ADDR_LEN-1:0] aw_addr [NM];
    logic [ADDR_LEN-1:0] ar_addr [NM];
    logic [WxDATA_W-1:0] w_pay   [NM];

    axi_lite_rr_arbiter #(
        .NUM_M(NM)
    ) dut (
        .aclk_i      (clk),
        .areset_i    (rst),
        .s_awvalid_i (s_awvalid),
        .s_awaddr_i  (s_awaddr),
        .s_awready_o (s_awready),
        .s_wvalid_i  (s_wvalid),
        .s_wdata_i   (s_wdata),
        .s_wready_o  (s_wready),
        .s_bvalid_o  (s_bvalid),
        .s_bresp_o   (s_bresp),
        .s_bready_i  (s_bready),
        .s_arvalid_i (s_arvalid),
        .s_araddr_i  (s_araddr),
        .s_arready_o (s_arready),
        .s_rvalid_o  (s_rvalid),
        .s_rdata_o   (s_rdata),
        .s_rready_i  (s_rready),
        .m_awvalid_o (m_awvalid),
        .m_awaddr_o  (m_awaddr),
        .m_awready_i (m_awready),
        .m_wvalid_o  (m_wvalid),
        .m_wdata_o   (m_wdata),
        .m_wready_i  (m_wready),
        .m_bvalid_i  (m_bvalid),
        .m_bresp_i   (m_bresp),
        .m_bready_o  (m_bready),
        .m_arvalid_o (m_arvalid),
        .m_araddr_o  (m_araddr),
        .m_arready_i (m_arready),
        .m_rvalid_i  (m_rvalid),
        .m_rdata_i   (m_rdata),
        .m_rready_o  (m_rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 128'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                       s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 128'(0));
    endtask

    // Reference arbitration: first requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [NM-1:0] req, input int ptr);
        for (int k = 0; k < NM; k++) begin
            if (req[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return 0;
    endfunction

    function automatic logic [NM-1:0] oh(input int m);
        return NM'(1) << m;
    endfunction

    function automatic logic [ADDR_LEN-1:0] mk_addr(input int m);
        return {4'(m), 28'($urandom)};
    endfunction

    function automatic logic [WxDATA_W-1:0] rnd_wpay();
        return {$urandom, $urandom, 8'($urandom)};
    endfunction

    function automatic logic [RxDATA_W-1:0] rnd_rpay();
        return {$urandom, $urandom, 2'($urandom)};
    endfunction

    task automatic set_aw(input int m, input logic [ADDR_LEN-1:0] a, input logic [WxDATA_W-1:0] p);
        aw_addr[m]                         = a;
        w_pay[m]                           = p;
        s_awaddr[m*ADDR_LEN +: ADDR_LEN]   = a;
        s_wdata[m*WxDATA_W +: WxDATA_W]    = p;
        s_awvalid[m]                       = 1'b1;
        s_wvalid[m]                        = 1'b1;
    endtask

    task automatic set_ar(input int m, input logic [ADDR_LEN-1:0] a);
        ar_addr[m]                       = a;
        s_araddr[m*ADDR_LEN +: ADDR_LEN] = a;
        s_arvalid[m]                     = 1'b1;
    endtask

    // Runs one write through the subordinate side; the winner comes from the model.
    task automatic wr_serve(input int aw_w, input int w_w, input int b_w, input int br_w,
                            input logic [1:0] resp, input int late_m,
                            output int cyc, output int who);
        int exp, n, t0;
        t0  = cyc_cnt;
        exp = rr_pick(s_awvalid, wptr_m);
        who = exp;
        n   = 0;
        while (m_awvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("aw_grant_seen", 128'(m_awvalid), 128'(1));
        chk("m_awaddr", 128'(m_awaddr), 128'(aw_addr[exp]));
        chk("m_wvalid_in_addr", 128'(m_wvalid), 128'(0));
        repeat (aw_w) begin
            m_awready = 1'b0;
            #1;
            chk("s_awready_wait", 128'(s_awready), 128'(0));
            tick();
        end
        m_awready = 1'b1;
        #1;
        chk("s_awready", 128'(s_awready), 128'(oh(exp)));
        tick();
        m_awready    = 1'b0;
        s_awvalid[exp] = 1'b0;
        #1;
        chk("m_awvalid_drop", 128'(m_awvalid), 128'(0));
        chk("m_wvalid", 128'(m_wvalid), 128'(1));
        chk("m_wdata", 128'(m_wdata), 128'(w_pay[exp]));
        repeat (w_w) begin
            m_wready = 1'b0;
            #1;
            chk("s_wready_wait", 128'(s_wready), 128'(0));
            tick();
        end
        m_wready = 1'b1;
        #1;
        chk("s_wready", 128'(s_wready), 128'(oh(exp)));
        tick();
        m_wready      = 1'b0;
        s_wvalid[exp] = 1'b0;
        if (late_m >= 0) set_aw(late_m, mk_addr(late_m), rnd_wpay());
        repeat (b_w) begin
            m_bvalid = 1'b0;
            #1;
            chk("s_bvalid_wait", 128'(s_bvalid), 128'(0));
            chk("no_new_aw", 128'(m_awvalid), 128'(0));
            tick();
        end
        m_bvalid = 1'b1;
        m_bresp  = resp;
        repeat (br_w) begin
            s_bready[exp] = 1'b0;
            #1;
            chk("s_bvalid_held", 128'(s_bvalid), 128'(oh(exp)));
            chk("m_bready_low", 128'(m_bready), 128'(0));
            chk("no_new_aw_b", 128'(m_awvalid), 128'(0));
            tick();
        end
        s_bready[exp] = 1'b1;
        #1;
        chk("s_bvalid", 128'(s_bvalid), 128'(oh(exp)));
        chk("m_bready", 128'(m_bready), 128'(1));
        chk("s_bresp", 128'(s_bresp), 128'(resp));
        tick();
        m_bvalid      = 1'b0;
        s_bready[exp] = 1'b0;
        wptr_m        = (exp + 1) % NM;
        cyc           = cyc_cnt - t0;
    endtask

    task automatic rd_serve(input int ar_w, input int r_w, input int rr_w,
                            input logic [RxDATA_W-1:0] pay, output int cyc, output int who);
        int exp, n, t0;
        t0  = cyc_cnt;
        exp = rr_pick(s_arvalid, rptr_m);
        who = exp;
        n   = 0;
        while (m_arvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("ar_grant_seen", 128'(m_arvalid), 128'(1));
        chk("m_araddr", 128'(m_araddr), 128'(ar_addr[exp]));
        chk("s_rvalid_in_addr", 128'(s_rvalid), 128'(0));
        repeat (ar_w) begin
            m_arready = 1'b0;
            #1;
            chk("s_arready_wait", 128'(s_arready), 128'(0));
            tick();
        end
        m_arready = 1'b1;
        #1;
        chk("s_arready", 128'(s_arready), 128'(oh(exp)));
        tick();
        m_arready      = 1'b0;
        s_arvalid[exp] = 1'b0;
        #1;
        chk("m_arvalid_drop", 128'(m_arvalid), 128'(0));
        repeat (r_w) begin
            m_rvalid = 1'b0;
            #1;
            chk("s_rvalid_wait", 128'(s_rvalid), 128'(0));
            chk("no_new_ar", 128'(m_arvalid), 128'(0));
            tick();
        end
        m_rvalid = 1'b1;
        m_rdata  = pay;
        repeat (rr_w) begin
            s_rready[exp] = 1'b0;
            #1;
            chk("s_rvalid_held", 128'(s_rvalid), 128'(oh(exp)));
            chk("m_rready_low", 128'(m_rready), 128'(0));
            tick();
        end
        s_rready[exp] = 1'b1;
        #1;
        chk("s_rvalid", 128'(s_rvalid), 128'(oh(exp)));
        chk("m_rready", 128'(m_rready), 128'(1));
        chk("s_rdata", 128'(s_rdata), 128'(pay));
        tick();
        m_rvalid      = 1'b0;
        s_rready[exp] = 1'b0;
        rptr_m        = (exp + 1) % NM;
        cyc           = cyc_cnt - t0;
    endtask

    initial begin
        int n;
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        s_awaddr  = '0; s_araddr = '0; s_wdata  = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        wptr_m = 0;
        rptr_m = 0;
        repeat (3) tick();
        chk_idle("reset_outputs");
        rst = 1'b0;
        tick();
        chk_idle("idle_after_reset");

        // Simultaneous writes from 0 and 1, twice: 0,1 then 0 again.
        set_aw(0, mk_addr(0), rnd_wpay());
        set_aw(1, mk_addr(1), rnd_wpay());
        wr_serve(0, 0, 0, 0, RespOkay, -1, cyc_w, who_w);
        wr_serve(0, 0, 0, 0, RespOkay, -1, cyc_w, who_w);
        set_aw(0, mk_addr(0), rnd_wpay());
        set_aw(1, mk_addr(1), rnd_wpay());
        wr_serve(0, 0, 0, 0, RespOkay, -1, cyc_w, who_w);
        wr_serve(0, 0, 0, 0, RespOkay, -1, cyc_w, who_w);

        // Single write from manager 0 against a zero-wait subordinate.
        set_aw(0, 32'h10, {64'hA5, 8'hFF});
        wr_serve(0, 0, 0, 0, RespOkay, -1, cyc_w, who_w);
        chk("wr_latency", 128'(cyc_w), 128'(4));

        // Concurrent write (manager 0) and read (manager 1).
        set_aw(0, mk_addr(0), rnd_wpay());
        set_ar(1, mk_addr(1));
        fork
            wr_serve(0, 1, 0, 0, RespOkay, -1, cyc_w, who_w);
            rd_serve(0, 0, 0, {64'hDEAD, RespSlvErr}, cyc_r, who_r);
        join
        chk("rd_latency", 128'(cyc_r), 128'(3));

        // Delayed B with another manager waiting, then bready held low.
        set_aw(1, mk_addr(1), rnd_wpay());
        wr_serve(0, 0, 5, 0, RespOkay, 0, cyc_w, who_w);
        wr_serve(0, 0, 0, 0, RespExOkay, -1, cyc_w, who_w);
        set_aw(1, mk_addr(1), rnd_wpay());
        wr_serve(0, 0, 0, 3, RespDecErr, -1, cyc_w, who_w);

        // Reset while manager 2's write sits in the data phase.
        set_aw(2, mk_addr(2), rnd_wpay());
        n = 0;
        while (m_awvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("t5_aw_granted", 128'(m_awaddr), 128'(aw_addr[2]));
        m_awready = 1'b1;
        tick();
        m_awready    = 1'b0;
        s_awvalid[2] = 1'b0;
        #1;
        chk("t5_in_wdata", 128'(m_wvalid), 128'(1));
        m_wready = 1'b1;
        rst      = 1'b1;
        tick();
        chk_idle("t5_reset_in_wdata");
        rst         = 1'b0;
        m_wready    = 1'b0;
        s_wvalid[2] = 1'b0;
        wptr_m      = 0;
        rptr_m      = 0;
        set_aw(1, mk_addr(1), rnd_wpay());
        set_aw(2, mk_addr(2), rnd_wpay());
        wr_serve(0, 0, 0, 0, RespOkay, -1, cyc_w, who_w);
        chk("t5_latency", 128'(cyc_w), 128'(4));
        wr_serve(0, 0, 0, 0, RespOkay, -1, cyc_w, who_w);

        // Three managers requesting reads continuously.
        for (int m = 0; m < NM; m++) set_ar(m, mk_addr(m));
        repeat (6) begin
            rd_serve(0, 0, 0, rnd_rpay(), cyc_r, who_r);
            set_ar(who_r, mk_addr(who_r));
        end
        while (s_arvalid != '0) rd_serve(0, 0, 0, rnd_rpay(), cyc_r, who_r);

        // Random request mixes with random subordinate/manager wait states.
        for (int it = 0; it < 25; it++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 1) == 1) set_aw(m, mk_addr(m), rnd_wpay());
                if ($urandom_range(0, 1) == 1) set_ar(m, mk_addr(m));
            end
            fork
                while (s_awvalid != '0)
                    wr_serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                             2'($urandom), -1, cyc_w, who_w);
                while (s_arvalid != '0)
                    rd_serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)), rnd_rpay(), cyc_r, who_r);
            join
        end
        tick();
        chk_idle("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
